// File: rtl/bus_arbiter.sv
// Two-master arbiter for the device bus: fixed priority to master 0, with a
// starvation counter that forces a master 1 slot after MAX_WAIT lost arbitrations.
module bus_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_stall,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_rd,
    output logic [1:0]  owner,
    output logic [3:0]  m1_wait
);

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_SAT = 4'hF;

    logic [1:0]  owner_q, owner_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_byteen_q, bus_byteen_d;
    logic [31:0] bus_wd_q, bus_wd_d;
    logic [3:0]  m1_wait_q, m1_wait_d;
    logic        elig0, elig1;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_IDLE;
            bus_addr_q   <= '0;
            bus_byteen_q <= '0;
            bus_wd_q     <= '0;
            m1_wait_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            bus_addr_q   <= bus_addr_d;
            bus_byteen_q <= bus_byteen_d;
            bus_wd_q     <= bus_wd_d;
            m1_wait_q    <= m1_wait_d;
        end
    end

    // A master being acked this cycle is excluded so its still-high req is not issued twice.
    always_comb begin
        elig0        = m0_req & ~m0_ack;
        elig1        = m1_req & ~m1_ack;
        owner_d      = OWN_IDLE;
        bus_addr_d   = '0;
        bus_byteen_d = '0;
        bus_wd_d     = '0;
        m1_wait_d    = '0;

        if (elig1 && (m1_wait_q >= WAIT_LIM)) begin
            owner_d = OWN_M1;
        end else if (elig0) begin
            owner_d = OWN_M0;
        end else if (elig1) begin
            owner_d = OWN_M1;
        end

        case (owner_d)
            OWN_M0: begin
                bus_addr_d   = m0_addr;
                bus_byteen_d = m0_byteen;
                bus_wd_d     = m0_wd;
            end
            OWN_M1: begin
                bus_addr_d   = m1_addr;
                bus_byteen_d = m1_byteen;
                bus_wd_d     = m1_wd;
            end
            default: ;
        endcase

        if (elig1 && (owner_d != OWN_M1)) begin
            m1_wait_d = (m1_wait_q == WAIT_SAT) ? WAIT_SAT : m1_wait_q + 4'd1;
        end
    end

    always_comb begin
        m0_ack     = (owner_q == OWN_M0);
        m1_ack     = (owner_q == OWN_M1);
        m0_rdata   = m0_ack ? bus_rd : 32'h0;
        m1_rdata   = m1_ack ? bus_rd : 32'h0;
        m0_stall   = m0_req & ~m0_ack;
        m1_stall   = m1_req & ~m1_ack;
        owner      = owner_q;
        bus_addr   = bus_addr_q;
        bus_byteen = bus_byteen_q;
        bus_wd     = bus_wd_q;
        m1_wait    = m1_wait_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_WAIT 4 and 2) share the master inputs
// and are checked every cycle against a rule-level model plus directed scenarios.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd;
    logic [3:0]  m0_byteen, m1_byteen;

    logic        m0_ack_w [2];
    logic        m1_ack_w [2];
    logic        m0_stall_w [2];
    logic        m1_stall_w [2];
    logic [31:0] m0_rdata_w [2];
    logic [31:0] m1_rdata_w [2];
    logic [31:0] bus_addr_w [2];
    logic [3:0]  bus_byteen_w [2];
    logic [31:0] bus_wd_w [2];
    logic [31:0] bus_rd_w [2];
    logic [1:0]  owner_w [2];
    logic [3:0]  m1_wait_w [2];

    logic [31:0] mem [2][64];

    int          MAXW [2] = '{4, 2};
    int          mdl_owner [2];
    int          mdl_wait [2];
    logic [31:0] mdl_addr [2];
    logic [3:0]  mdl_be [2];
    logic [31:0] mdl_wd [2];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit ack_prev0 = 1'b0;
    bit ack_prev1 = 1'b0;
    int m1_lat = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_arbiter #(.MAX_WAIT(g == 0 ? 4 : 2)) u_dut (
            .clk(clk), .reset(reset),
            .m0_req(m0_req), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wd(m0_wd),
            .m0_ack(m0_ack_w[g]), .m0_rdata(m0_rdata_w[g]), .m0_stall(m0_stall_w[g]),
            .m1_req(m1_req), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wd(m1_wd),
            .m1_ack(m1_ack_w[g]), .m1_rdata(m1_rdata_w[g]), .m1_stall(m1_stall_w[g]),
            .bus_addr(bus_addr_w[g]), .bus_byteen(bus_byteen_w[g]), .bus_wd(bus_wd_w[g]),
            .bus_rd(bus_rd_w[g]), .owner(owner_w[g]), .m1_wait(m1_wait_w[g])
        );
        assign bus_rd_w[g] = mem[g][bus_addr_w[g][7:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bridge stand-in: writes land on the edge after the bus carries them, reset or not.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_byteen_w[g][b])
                    mem[g][bus_addr_w[g][7:2]][8*b +: 8] <= bus_wd_w[g][8*b +: 8];
            end
        end
    end

    // Reference: 0 idle, 1 master 0, 2 master 1.
    function automatic int pick(int g);
        bit e0, e1;
        e0 = m0_req && (mdl_owner[g] != 1);
        e1 = m1_req && (mdl_owner[g] != 2);
        if (e1 && (mdl_wait[g] >= MAXW[g])) return 2;
        if (e0) return 1;
        if (e1) return 2;
        return 0;
    endfunction

    function automatic int next_wait(int g, int sel);
        bit e1;
        e1 = m1_req && (mdl_owner[g] != 2);
        if (sel == 2 || !e1) return 0;
        return (mdl_wait[g] >= 15) ? 15 : mdl_wait[g] + 1;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                mdl_owner[g] <= 0;
                mdl_wait[g]  <= 0;
                mdl_addr[g]  <= '0;
                mdl_be[g]    <= '0;
                mdl_wd[g]    <= '0;
            end else begin
                mdl_owner[g] <= pick(g);
                mdl_wait[g]  <= next_wait(g, pick(g));
                mdl_addr[g]  <= (pick(g) == 1) ? m0_addr   : (pick(g) == 2) ? m1_addr   : 32'h0;
                mdl_be[g]    <= (pick(g) == 1) ? m0_byteen : (pick(g) == 2) ? m1_byteen : 4'h0;
                mdl_wd[g]    <= (pick(g) == 1) ? m0_wd     : (pick(g) == 2) ? m1_wd     : 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                logic [31:0] rexp;
                rexp = mem[g][mdl_addr[g][7:2]];
                check("owner",    owner_w[g],      mdl_owner[g][1:0]);
                check("m1_wait",  m1_wait_w[g],    mdl_wait[g][3:0]);
                check("bus_addr", bus_addr_w[g],   mdl_addr[g]);
                check("bus_be",   bus_byteen_w[g], mdl_be[g]);
                check("bus_wd",   bus_wd_w[g],     mdl_wd[g]);
                check("m0_ack",   m0_ack_w[g],     mdl_owner[g] == 1);
                check("m1_ack",   m1_ack_w[g],     mdl_owner[g] == 2);
                check("m0_rdata", m0_rdata_w[g],   (mdl_owner[g] == 1) ? rexp : 32'h0);
                check("m1_rdata", m1_rdata_w[g],   (mdl_owner[g] == 2) ? rexp : 32'h0);
                check("m0_stall", m0_stall_w[g],   m0_req && (mdl_owner[g] != 1));
                check("m1_stall", m1_stall_w[g],   m1_req && (mdl_owner[g] != 2));
            end
            check("one_ack", m0_ack_w[0] & m1_ack_w[0], 1'b0);
            if (reset || !m1_req) begin
                m1_lat = 0;
            end else if (m1_ack_w[0]) begin
                check("m1_lat_le3", m1_lat <= 3, 1'b1);
                m1_lat = 0;
            end else begin
                m1_lat++;
            end
        end
        ack_prev0 = (mdl_owner[0] == 1);
        ack_prev1 = (mdl_owner[0] == 2);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? 32'h0000_7F00 : ($urandom & 32'h0000_00FC);
    endfunction

    function automatic logic [3:0] rnd_be();
        return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endfunction

    initial begin
        bit got;
        int k;
        reset = 1'b1;
        m0_req = 0; m0_addr = 0; m0_byteen = 0; m0_wd = 0;
        m1_req = 0; m1_addr = 0; m1_byteen = 0; m1_wd = 0;
        repeat (3) cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_owner", owner_w[0], 2'b00);
        check("rst_be",    bus_byteen_w[0], 4'h0);
        cyc();
        reset = 1'b0;

        // M0 write, then read back
        m0_req = 1; m0_addr = 32'h10; m0_byteen = 4'hF; m0_wd = 32'hDEADBEEF;
        cyc();
        @(negedge clk);
        check("wr_ack",  m0_ack_w[0], 1'b1);
        check("wr_addr", bus_addr_w[0], 32'h10);
        check("wr_be",   bus_byteen_w[0], 4'hF);
        cyc();
        m0_byteen = 4'h0; m0_wd = 32'h0;
        cyc();
        @(negedge clk);
        check("rd_back", m0_rdata_w[0], 32'hDEADBEEF);
        cyc();
        m0_req = 0;
        cyc();

        // TIMER0 read
        m0_req = 1; m0_addr = 32'h7F00; m0_byteen = 4'h0;
        cyc();
        @(negedge clk);
        check("tmr_rd",  m0_rdata_w[0], bus_rd_w[0]);
        check("tmr_m1",  m1_rdata_w[0], 32'h0);
        cyc();
        m0_req = 0;
        cyc();

        // simultaneous single requests
        m0_req = 1; m0_addr = 32'h20; m0_byteen = 4'h3; m0_wd = 32'h1111_2222;
        m1_req = 1; m1_addr = 32'h24; m1_byteen = 4'hC; m1_wd = 32'h3333_4444;
        cyc();
        @(negedge clk);
        check("sim_m0", m0_ack_w[0], 1'b1);
        check("sim_m1", m1_ack_w[0], 1'b0);
        check("sim_w1", m1_wait_w[0], 4'd1);
        cyc();
        m0_req = 0;
        @(negedge clk);
        check("sim_m1b", m1_ack_w[0], 1'b1);
        check("sim_w0",  m1_wait_w[0], 4'd0);
        cyc();
        m1_req = 0;
        cyc();

        // both masters hold req: strict alternation
        m0_req = 1; m0_byteen = 4'h0; m1_req = 1; m1_byteen = 4'h0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            @(negedge clk);
            check("alt", m0_ack_w[0] ^ m1_ack_w[0], 1'b1);
            check("alt_w", m1_wait_w[0] <= 4'd1, 1'b1);
        end
        m0_req = 0; m1_req = 0;
        cyc(); cyc();

        // M1 against a persistent M0, MAX_WAIT=2 instance
        m0_req = 1; m1_req = 1;
        got = 0; k = 0;
        while (!got && k < 6) begin
            cyc();
            k++;
            @(negedge clk);
            if (m1_ack_w[1]) got = 1;
        end
        check("starve", got && (k <= 3), 1'b1);
        m0_req = 0; m1_req = 0;
        cyc(); cyc();

        // reset during a BUS1 cycle
        m1_req = 1; m1_addr = 32'h30; m1_byteen = 4'hF; m1_wd = 32'hCAFE_F00D;
        cyc();
        @(negedge clk);
        check("b1_ack", m1_ack_w[0], 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_own", owner_w[0], 2'b00);
        check("rst_ack", {m0_ack_w[0], m1_ack_w[0]}, 2'b00);
        check("rst_be2", bus_byteen_w[0], 4'h0);
        check("rst_w",   m1_wait_w[0], 4'd0);
        cyc();
        @(negedge clk);
        check("regrant", m1_ack_w[0], 1'b1);
        cyc();
        m1_req = 0;
        cyc();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!m0_req || ack_prev0) begin
                if ($urandom_range(0, 2) != 0) begin
                    m0_req = 1; m0_addr = rnd_addr(); m0_byteen = rnd_be(); m0_wd = $urandom;
                end else begin
                    m0_req = 0;
                end
            end
            if (!m1_req || ack_prev1) begin
                if ($urandom_range(0, 2) != 0) begin
                    m1_req = 1; m1_addr = rnd_addr(); m1_byteen = rnd_be(); m1_wd = $urandom;
                end else begin
                    m1_req = 0;
                end
            end
            cyc();
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
